// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared types for the execute stage. Defines the ALU opcode
//            enumeration, the MDU state encoding, the default datapath width
//            and small opcode classification helpers.
// Ports    : none (package)
// Config   : MIPS_MDU_DIV_EN is not referenced here. It is used in
//            ex_stage.sv and mdu_iter.sv.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI,
    MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mdu_state_e;

  // Ops that read or write HI/LO directly and so must wait for the MDU.
  function automatic logic is_hilo_op(input alu_op_e op);
    return (op == MFHI) || (op == MFLO) || (op == MTHI) || (op == MTLO);
  endfunction

  function automatic logic is_mul_op(input alu_op_e op);
    return (op == MULT) || (op == MULTU);
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// Module   : mdu_iter
// Purpose  : Iterative multiply/divide unit with HI/LO. It retires one bit
//            per cycle. A shift-add multiplier or a restoring divider works
//            on operand magnitudes, and the result sign is fixed in DONE.
// Ports    : clk, rst      clock and synchronous active-high reset
//            start         begin an op (only sampled while IDLE)
//            op            MULT/MULTU (DIV/DIVU when the divider is built)
//            op_a, op_b    rs / rt operands
//            hi_we, lo_we  MTHI / MTLO writes of wdata
//            busy          RUN or DONE
//            hi, lo        architectural HI/LO
// Config   : MIPS_MDU_DIV_EN builds the divider. Without it, only MULT and
//            MULTU can start the unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_iter
  import mips_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MDU_ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(MDU_ITER + 1);

  mdu_state_e        state, state_nxt;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;        // mul: {partial, multiplier}; div: {rem, quotient}
  logic [XLEN-1:0]   operand;    // multiplicand magnitude or divisor magnitude
  logic              neg_lo;     // negate product / quotient on completion

  logic              op_signed;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc_init, acc_step;
  logic [XLEN-1:0]   operand_init;
  logic [XLEN-1:0]   res_hi, res_lo;
  logic [XLEN:0]     mul_sum;

`ifdef MIPS_MDU_DIV_EN
  logic              is_div;
  logic              neg_hi;     // remainder takes the dividend's sign
  logic              div_zero;
  logic [XLEN-1:0]   raw_a;      // unmodified dividend, returned in HI on /0
  logic              start_div;
  logic [XLEN:0]     div_shift, div_diff;
`endif

  // --------------------------------------------------------------------------
  // Operand conditioning at start
  // --------------------------------------------------------------------------
  always_comb begin
    op_signed = (op == MULT);
`ifdef MIPS_MDU_DIV_EN
    start_div = is_div_op(op);
    if (op == DIV) op_signed = 1'b1;
`endif
    a_neg = op_signed & op_a[XLEN-1];
    b_neg = op_signed & op_b[XLEN-1];
    mag_a = a_neg ? -op_a : op_a;
    mag_b = b_neg ? -op_b : op_b;
    // The multiplier sits in the low half and is consumed LSB first.
    acc_init     = {{XLEN{1'b0}}, mag_b};
    operand_init = mag_a;
`ifdef MIPS_MDU_DIV_EN
    // The dividend is shifted into the remainder MSB first.
    if (start_div) begin
      acc_init     = {{XLEN{1'b0}}, mag_a};
      operand_init = mag_b;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // One iteration step
  // --------------------------------------------------------------------------
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
    acc_step = acc[0] ? {mul_sum, acc[XLEN-1:1]}
                      : {1'b0, acc[2*XLEN-1:1]};
`ifdef MIPS_MDU_DIV_EN
    // The remainder is always below the divisor, so XLEN+1 bits hold the shift.
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, operand};
    if (is_div) begin
      acc_step = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Final result with sign correction and divide special cases
  // --------------------------------------------------------------------------
  always_comb begin
    {res_hi, res_lo} = neg_lo ? -acc : acc;
`ifdef MIPS_MDU_DIV_EN
    if (is_div) begin
      if (div_zero) begin
        res_hi = raw_a;
        res_lo = '1;
      end else begin
        // 0x8000_0000 / -1 falls out naturally: |q| = 2^31 negates to itself.
        res_hi = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        res_lo = neg_lo ? -acc[XLEN-1:0]      : acc[XLEN-1:0];
      end
    end
`endif
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // --------------------------------------------------------------------------
  // Datapath and HI/LO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      neg_lo   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MIPS_MDU_DIV_EN
      is_div   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      raw_a    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count    <= CW'(MDU_ITER);
            acc      <= acc_init;
            operand  <= operand_init;
            neg_lo   <= a_neg ^ b_neg;
`ifdef MIPS_MDU_DIV_EN
            is_div   <= start_div;
            neg_hi   <= a_neg;
            div_zero <= (op_b == '0);
            raw_a    <= op_a;
`endif
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count - CW'(1);
        end
        DONE: begin
          hi <= res_hi;
          lo <= res_lo;
        end
        default: ;
      endcase
      // The upstream stall keeps MTHI/MTLO out while the unit is busy.
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage plus the EX/MEM pipeline register. It contains the
//            single-cycle ALU, the HI/LO hazard stall and the iterative MDU.
// Ports    : clk, rst             clock, synchronous active-high reset
//            exValid, flush       ID/EX valid and kill of the EX instruction
//            aluOp, shamt         operation and shift amount
//            opA, opB, rtData     operands and store data
//            destReg, MemtoReg, RegWrite, MemRead, MemWrite, Branch
//                                 control carried to MEM
//            stall                combinational hold request to ID/EX
//            mduBusy              MDU iterating
//            aluOut, writeData, destRegOut, *Out, zeroOut
//                                 registered EX/MEM outputs
// Config   : MIPS_MDU_DIV_EN enables DIV/DIVU on the MDU. When it is not
//            defined they retire as NOPs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MDU_ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exValid,
  input  logic            flush,
  input  alu_op_e         aluOp,
  input  logic [4:0]      shamt,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [XLEN-1:0] rtData,
  input  logic [4:0]      destReg,
  input  logic            MemtoReg,
  input  logic            RegWrite,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            Branch,
  output logic            stall,
  output logic            mduBusy,
  output logic [XLEN-1:0] aluOut,
  output logic [XLEN-1:0] writeData,
  output logic [4:0]      destRegOut,
  output logic            MemtoRegOut,
  output logic            RegWriteOut,
  output logic            MemReadOut,
  output logic            MemWriteOut,
  output logic            BranchOut,
  output logic            zeroOut
);

  logic            is_mdu_op;
  logic            is_hilo;
  logic            issue;
  logic            mdu_busy;
  logic [XLEN-1:0] hi, lo;
  logic [XLEN-1:0] alu_res;

  always_comb begin
    is_mdu_op = is_mul_op(aluOp);
`ifdef MIPS_MDU_DIV_EN
    if (is_div_op(aluOp)) is_mdu_op = 1'b1;
`endif
    is_hilo = is_hilo_op(aluOp);
  end

  // HI/LO readers and writers, and a second MDU op, must wait for the MDU.
  assign stall   = exValid & ~flush & (is_mdu_op | is_hilo) & mdu_busy;
  assign issue   = exValid & ~flush & ~stall;
  assign mduBusy = mdu_busy;

  mdu_iter #(
    .XLEN     (XLEN),
    .MDU_ITER (MDU_ITER)
  ) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .start (issue & is_mdu_op),
    .op    (aluOp),
    .op_a  (opA),
    .op_b  (opB),
    .hi_we (issue & (aluOp == MTHI)),
    .lo_we (issue & (aluOp == MTLO)),
    .wdata (opA),
    .busy  (mdu_busy),
    .hi    (hi),
    .lo    (lo)
  );

  // --------------------------------------------------------------------------
  // Single-cycle ALU. MDU ops, MTHI/MTLO and disabled DIV/DIVU produce 0.
  // --------------------------------------------------------------------------
  always_comb begin
    alu_res = '0;
    case (aluOp)
      ADD:     alu_res = opA + opB;
      SUB:     alu_res = opA - opB;
      AND:     alu_res = opA & opB;
      OR:      alu_res = opA | opB;
      XOR:     alu_res = opA ^ opB;
      NOR:     alu_res = ~(opA | opB);
      SLT:     alu_res = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
      SLTU:    alu_res = {{(XLEN-1){1'b0}}, (opA < opB)};
      SLL:     alu_res = opB << shamt;
      SRL:     alu_res = opB >> shamt;
      SRA:     alu_res = $signed(opB) >>> shamt;
      LUI:     alu_res = {opB[15:0], {(XLEN-16){1'b0}}};
      MFHI:    alu_res = hi;
      MFLO:    alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // EX/MEM register: loads every cycle, and inserts a bubble when not issuing
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || !issue) begin
      aluOut      <= '0;
      writeData   <= '0;
      destRegOut  <= '0;
      MemtoRegOut <= 1'b0;
      RegWriteOut <= 1'b0;
      MemReadOut  <= 1'b0;
      MemWriteOut <= 1'b0;
      BranchOut   <= 1'b0;
      zeroOut     <= 1'b0;
    end else begin
      aluOut      <= alu_res;
      writeData   <= rtData;
      destRegOut  <= destReg;
      MemtoRegOut <= MemtoReg;
      RegWriteOut <= RegWrite;
      MemReadOut  <= MemRead;
      MemWriteOut <= MemWrite;
      BranchOut   <= Branch;
      zeroOut     <= (alu_res == '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Scoreboard bench for ex_stage. A driver issues directed and
//            random instructions and pushes the expected EX/MEM contents
//            from a reference model. A monitor pops one entry per clock and
//            compares it with the outputs.
// Config   : follows MIPS_MDU_DIV_EN like the design.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_stage;
  import mips_pkg::*;

  localparam int ITER = 32;
`ifdef MIPS_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exValid = 1'b0, flush = 1'b0;
  alu_op_e     aluOp = ADD;
  logic [4:0]  shamt = '0, destReg = '0;
  logic [31:0] opA = '0, opB = '0, rtData = '0;
  logic        MemtoReg = 1'b0, RegWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, Branch = 1'b0;
  logic        stall, mduBusy, zeroOut;
  logic [31:0] aluOut, writeData;
  logic [4:0]  destRegOut;
  logic        MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut;

  ex_stage #(.XLEN(32), .MDU_ITER(ITER)) dut (
    .clk(clk), .rst(rst), .exValid(exValid), .flush(flush), .aluOp(aluOp),
    .shamt(shamt), .opA(opA), .opB(opB), .rtData(rtData), .destReg(destReg),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .stall(stall), .mduBusy(mduBusy),
    .aluOut(aluOut), .writeData(writeData), .destRegOut(destRegOut),
    .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut),
    .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
    .BranchOut(BranchOut), .zeroOut(zeroOut)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  dst;
    logic [4:0]  ctrl;  // {MemtoReg, RegWrite, MemRead, MemWrite, Branch}
    logic        zero;
    bit          full;  // also compare writeData/destRegOut
  } exp_t;
  exp_t exp_q[$];

  // Reference model: architectural HI/LO plus one pending MDU result that
  // becomes visible ITER+2 cycles after its issue cycle.
  longint      cyc = 0;
  bit          mdu_act = 1'b0;
  longint      mdu_t = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [31:0] ref_alu(input alu_op_e op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      ADD:  return a + b;
      SUB:  return a - b;
      AND:  return a & b;
      OR:   return a | b;
      XOR:  return a ^ b;
      NOR:  return ~(a | b);
      SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU: return (a < b) ? 32'd1 : 32'd0;
      SLL:  return b << sh;
      SRL:  return b >> sh;
      SRA:  return 32'($signed(b) >>> sh);
      LUI:  return {b[15:0], 16'h0000};
      MFHI: return m_hi;
      MFLO: return m_lo;
      default: return 32'h0;
    endcase
  endfunction

  task automatic mdu_model(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] pr, tq, tr;
    sa = $signed(a);
    sb = $signed(b);
    pr = '0;
    case (op)
      MULT:  pr = sa * sb;
      MULTU: pr = {32'h0, a} * {32'h0, b};
      DIV: begin
        if (b == 0) pr = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb; sr = sa % sb;
          tq = sq; tr = sr;
          pr = {tr[31:0], tq[31:0]};
        end
      end
      DIVU: pr = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: pr = '0;
    endcase
    p_hi = pr[63:32];
    p_lo = pr[31:0];
  endtask

  // One clock of stimulus with its expectation.
  task automatic cycle(input bit v, input bit fl, input bit rs, input alu_op_e op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] rt,
                       input logic [4:0] sh, input logic [4:0] dst, input logic [4:0] ctrl,
                       output bit iss);
    bit   busy_m, stall_m, mdu_op;
    exp_t e;
    @(negedge clk);
    if (mdu_act && cyc == mdu_t + ITER + 2) begin
      m_hi = p_hi; m_lo = p_lo; mdu_act = 1'b0;
    end
    rst = rs; exValid = v; flush = fl; aluOp = op; opA = a; opB = b; rtData = rt;
    shamt = sh; destReg = dst;
    {MemtoReg, RegWrite, MemRead, MemWrite, Branch} = ctrl;
    busy_m  = mdu_act && (cyc > mdu_t);
    mdu_op  = (op == MULT) || (op == MULTU) || (DIV_EN && (op == DIV || op == DIVU));
    stall_m = v && !fl && busy_m &&
              (mdu_op || op == MFHI || op == MFLO || op == MTHI || op == MTLO);
    #1;
    if (!rs) begin
      chk("stall", {31'h0, stall}, {31'h0, stall_m});
      chk("mduBusy", {31'h0, mduBusy}, {31'h0, busy_m});
    end
    iss = v && !fl && !stall_m && !rs;
    e.alu = '0; e.wd = '0; e.dst = '0; e.ctrl = '0; e.zero = 1'b0; e.full = 1'b0;
    if (rs) begin
      e.full = 1'b1;
      mdu_act = 1'b0; m_hi = '0; m_lo = '0;
    end else if (iss) begin
      e.alu  = ref_alu(op, a, b, sh);
      e.wd   = rt; e.dst = dst; e.ctrl = ctrl;
      e.zero = (e.alu == 0);
      e.full = 1'b1;
      if (op == MTHI) m_hi = a;
      if (op == MTLO) m_lo = a;
      if (mdu_op) begin
        mdu_model(op, a, b);
        mdu_act = 1'b1; mdu_t = cyc;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    bit d;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, ADD, 0, 0, 0, 0, 0, 0, d);
  endtask

  task automatic reset_cycle();
    bit d;
    cycle(0, 0, 1, ADD, 0, 0, 0, 0, 0, 0, d);
  endtask

  // Present an instruction and hold it while stalled, as ID/EX would.
  task automatic issue_op(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] ctrl);
    bit iss;
    iss = 1'b0;
    for (int i = 0; i < 100 && !iss; i++)
      cycle(1, 0, 0, op, a, b, $urandom(), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), ctrl, iss);
    if (!iss) begin
      total++; bad++;
      $display("FAIL issue_timeout op=%s", op.name());
    end
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: one EX/MEM expectation per clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("aluOut", aluOut, e.alu);
        chk("ctrlOut", {27'h0, MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut},
            {27'h0, e.ctrl});
        chk("zeroOut", {31'h0, zeroOut}, {31'h0, e.zero});
        if (e.full) begin
          chk("writeData", writeData, e.wd);
          chk("destRegOut", {27'h0, destRegOut}, {27'h0, e.dst});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit d;
    reset_cycle();
    reset_cycle();
    idle(1);

    // Add that wraps into the sign bit, with control bits mirrored
    cycle(1, 0, 0, ADD, 32'h7FFF_FFFF, 32'h1, 32'hCAFE_F00D, 0, 5'd9, 5'b10101, d);
    // Multiply followed by dependent HI/LO reads
    issue_op(MULT, 32'hFFFF_FFFD, 32'd5, 5'b00000);
    issue_op(MFLO, 0, 0, 5'b01000);
    issue_op(MFHI, 0, 0, 5'b01000);
    issue_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00000);
    issue_op(MFHI, 0, 0, 5'b01000);
    // Division and its corner cases
    issue_op(DIV, 32'hFFFF_FFF9, 32'd2, 5'b00000);
    issue_op(MFLO, 0, 0, 5'b01000);
    issue_op(MFHI, 0, 0, 5'b01000);
    issue_op(DIVU, 32'd7, 32'd0, 5'b00000);
    issue_op(MFLO, 0, 0, 5'b01000);
    issue_op(MFHI, 0, 0, 5'b01000);
    issue_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'b00000);
    issue_op(MFLO, 0, 0, 5'b01000);
    issue_op(MFHI, 0, 0, 5'b01000);
    // Flushed store and flushed multiply
    cycle(1, 1, 0, ADD, 32'h100, 32'h4, 32'h55, 0, 5'd3, 5'b00010, d);
    cycle(1, 1, 0, MULT, 32'd6, 32'd7, 0, 0, 0, 5'b00000, d);
    idle(2);
    issue_op(MFLO, 0, 0, 5'b01000);
    // Reset in the middle of a multiply
    issue_op(MULT, 32'd1234, 32'd5678, 5'b00000);
    idle(9);
    reset_cycle();
    issue_op(MFLO, 0, 0, 5'b01000);
    issue_op(MFHI, 0, 0, 5'b01000);
    // Divide after explicit HI/LO writes
    issue_op(MTHI, 32'h1111_2222, 0, 5'b00000);
    issue_op(MTLO, 32'h3333_4444, 0, 5'b00000);
    issue_op(DIV, 32'd8, 32'd2, 5'b00000);
    issue_op(MFHI, 0, 0, 5'b01000);
    issue_op(MFLO, 0, 0, 5'b01000);
    // ALU boundaries
    cycle(1, 0, 0, SUB, 32'h1234, 32'h1234, 0, 0, 5'd1, 5'b00001, d);
    cycle(1, 0, 0, SLT, 32'h8000_0000, 32'h1, 0, 0, 5'd2, 5'b01000, d);
    cycle(1, 0, 0, SLTU, 32'h8000_0000, 32'h1, 0, 0, 5'd2, 5'b01000, d);
    cycle(1, 0, 0, SRA, 0, 32'h8000_0000, 0, 5'd31, 5'd4, 5'b01000, d);
    cycle(1, 0, 0, LUI, 0, 32'hABCD_1234, 0, 0, 5'd5, 5'b01000, d);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit rs;
      rs = ($urandom_range(0, 299) == 0);
      cycle(rs ? 1'b0 : ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0), rs,
            alu_op_e'($urandom_range(0, 19)), rv(), rv(), $urandom(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), d);
    end

    idle(3);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
